// File: rtl/date_display_ctrl.sv
// Debounced two-key controller for the LED bank and the six-digit date display.
// key[0] toggles LED inversion; key[1] cycles the display mode A -> B -> AUTO.
module date_display_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned DWELL_CYCLES    = 100000000,
  parameter logic [23:0] DATE_A          = 24'h082301,
  parameter logic [23:0] DATE_B          = 24'h082401,
  parameter bit          SUPPRESS_LZ     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  key,
  input  logic [7:0]  switch,
  output logic [9:0]  leds,
  output logic [23:0] digits,
  output logic [5:0]  blank,
  output logic [1:0]  mode
);

  localparam int unsigned DebW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned DwellW = $clog2(DWELL_CYCLES);
  localparam logic [DebW-1:0]   DebMax   = DebW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DwellW-1:0] DwellMax = DwellW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    ShowA   = 2'd0,
    ShowB   = 2'd1,
    Auto    = 2'd2,
    Illegal = 2'd3
  } state_e;

  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      level_q, level_d;
  logic [1:0]      press;
  logic [DebW-1:0] cnt_q [2];
  logic [DebW-1:0] cnt_d [2];

  state_e            state_q, state_d;
  logic              sel_q, sel_d;
  logic              invert_q;
  logic [DwellW-1:0] dwell_q, dwell_d;
  logic [9:0]        leds_q;
  logic [23:0]       digits_q;

  // The press strobe fires in the cycle the debounced level commits from 1 to 0.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      level_d[i] = level_q[i];
      cnt_d[i]   = '0;
      press[i]   = 1'b0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == DebMax) begin
          level_d[i] = sync2_q[i];
          press[i]   = level_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    dwell_d = '0;
    case (state_q)
      ShowA: begin
        sel_d = 1'b0;
        if (press[1]) begin
          state_d = ShowB;
          sel_d   = 1'b1;
        end
      end
      ShowB: begin
        sel_d = 1'b1;
        if (press[1]) begin
          state_d = Auto;
          sel_d   = 1'b0;
        end
      end
      Auto: begin
        // A key[1] press beats a coincident dwell wrap.
        if (press[1]) begin
          state_d = ShowA;
          sel_d   = 1'b0;
        end else if (dwell_q == DwellMax) begin
          sel_d = ~sel_q;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      default: begin
        state_d = ShowA;
        sel_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 2'b11;
      sync2_q  <= 2'b11;
      level_q  <= 2'b11;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
      state_q  <= ShowA;
      sel_q    <= 1'b0;
      invert_q <= 1'b0;
      dwell_q  <= '0;
      leds_q   <= '0;
      digits_q <= DATE_A;
    end else begin
      sync1_q  <= key;
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
      state_q  <= state_d;
      sel_q    <= sel_d;
      invert_q <= invert_q ^ press[0];
      dwell_q  <= dwell_d;
      leds_q   <= {state_q == Auto, invert_q, switch ^ {8{invert_q}}};
      digits_q <= sel_q ? DATE_B : DATE_A;
    end
  end

  assign leds   = leds_q;
  assign digits = digits_q;
  assign blank  = {SUPPRESS_LZ & (digits_q[23:20] == 4'd0), 5'b0};
  assign mode   = state_q;

endmodule

// File: tb/tb_date_display_ctrl.sv
// Directed bench for date_display_ctrl with short debounce (4) and dwell (10) periods.
module tb_date_display_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  key;
  logic [7:0]  switch;
  logic [9:0]  leds;
  logic [23:0] digits;
  logic [5:0]  blank;
  logic [1:0]  mode;

  int checks   = 0;
  int failures = 0;

  localparam logic [23:0] DA = 24'h082301;
  localparam logic [23:0] DB = 24'h082401;

  date_display_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .DWELL_CYCLES   (10),
    .DATE_A         (DA),
    .DATE_B         (DB),
    .SUPPRESS_LZ    (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .key   (key),
    .switch(switch),
    .leds  (leds),
    .digits(digits),
    .blank (blank),
    .mode  (mode)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset  = 1'b1;
    key    = 2'b11;
    switch = 8'hA5;

    // Reset state
    tick(3);
    check("rst_leds", 32'(leds), 32'h000);
    check("rst_digits", 32'(digits), 32'(DA));
    check("rst_blank", 32'(blank), 32'b100000);
    check("rst_mode", 32'(mode), 32'd0);
    reset = 1'b0;
    tick(1);
    check("rel_leds", 32'(leds), 32'h0A5);

    // Short glitches on key[0] never commit
    for (int p = 0; p < 5; p++) begin
      key[0] = 1'b0;
      tick(3);
      key[0] = 1'b1;
      tick(3);
    end
    tick(8);
    check("glitch_leds", 32'(leds), 32'h0A5);

    // Clean key[0] press held 20 cycles: one toggle, leds at edge 7
    key[0] = 1'b0;
    tick(6);
    check("inv_before", 32'(leds), 32'h0A5);
    tick(1);
    check("inv_after", 32'(leds), 32'h15A);
    tick(13);
    check("inv_held", 32'(leds), 32'h15A);
    key[0] = 1'b1;
    tick(10);
    check("inv_release", 32'(leds), 32'h15A);

    // key[1] press 1: SHOW_B
    key[1] = 1'b0;
    tick(8);
    key[1] = 1'b1;
    tick(8);
    check("p1_mode", 32'(mode), 32'd1);
    check("p1_digits", 32'(digits), 32'(DB));
    check("p1_blank", 32'(blank), 32'b100000);

    // key[1] press 2: AUTO entered at edge 6 (E)
    key[1] = 1'b0;
    tick(6);
    check("p2_mode", 32'(mode), 32'd2);
    tick(1);
    key[1] = 1'b1;
    check("p2_leds", 32'(leds), 32'h35A);
    check("auto_e1", 32'(digits), 32'(DA));
    tick(9);
    check("auto_e10", 32'(digits), 32'(DA));
    tick(1);
    check("auto_e11", 32'(digits), 32'(DB));
    tick(9);
    check("auto_e20", 32'(digits), 32'(DB));
    tick(1);
    check("auto_e21", 32'(digits), 32'(DA));

    // key[1] press 3: back to SHOW_A
    key[1] = 1'b0;
    tick(7);
    check("p3_mode", 32'(mode), 32'd0);
    check("p3_digits", 32'(digits), 32'(DA));
    check("p3_leds", 32'(leds), 32'h15A);
    key[1] = 1'b1;
    tick(8);

    // Restore invert=0
    key[0] = 1'b0;
    tick(8);
    key[0] = 1'b1;
    tick(8);
    check("inv_clear", 32'(leds), 32'h0A5);

    // Simultaneous key[0] and key[1]
    key = 2'b00;
    tick(7);
    check("sim_mode", 32'(mode), 32'd1);
    check("sim_leds", 32'(leds), 32'h15A);
    key = 2'b11;
    tick(8);
    check("sim_digits", 32'(digits), 32'(DB));

    // Enter AUTO, reset when dwell counter is 6
    key[1] = 1'b0;
    tick(6);
    check("auto2_mode", 32'(mode), 32'd2);
    tick(1);
    key[1] = 1'b1;
    tick(5);
    reset  = 1'b1;
    key[1] = 1'b0;
    #2;
    check("arst_mode", 32'(mode), 32'd0);
    check("arst_digits", 32'(digits), 32'(DA));
    check("arst_leds", 32'(leds), 32'h000);
    check("arst_blank", 32'(blank), 32'b100000);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick(1);
    check("post_leds", 32'(leds), 32'h0A5);
    tick(4);
    check("post_mode5", 32'(mode), 32'd0);
    tick(1);
    check("post_mode6", 32'(mode), 32'd1);
    key[1] = 1'b1;
    tick(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/date_display_ctrl.md
Name: date_display_ctrl

Overview:
Controller for the board's LED and six-digit seven-segment display path. It debounces the two push-buttons and turns each press into a single event. key[0] toggles inversion of the switch-driven LEDs. key[1] steps a display-mode FSM that selects the date shown on the HEX digits: A, B, or alternating automatically. Its outputs feed the existing per-digit sevenSeg decoders (4-bit value per digit) plus per-digit blanking.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a key level is accepted (10 ms at 50 MHz); legal range >=1.
DWELL_CYCLES, 100000000, cycles each date is shown in AUTO mode (2 s at 50 MHz); legal range >=2.
DATE_A, 24'h082301, six BCD nibbles for date A; [23:20]=hex5 ... [3:0]=hex0.
DATE_B, 24'h082401, six BCD nibbles for date B, same packing.
SUPPRESS_LZ, 1, when 1 the hex5 digit is blanked while its nibble is 0.

Ports:
clk  input  1  system clock, 50 MHz.
reset  input  1  asynchronous, active-high; clears all state immediately.
key  input  2  raw push-buttons, active-low (0 = pressed), asynchronous to clk.
switch  input  8  slide switches, static levels.
leds  output  10  [7:0] switch data, optionally inverted; [8] invert flag; [9] 1 while mode is AUTO.
digits  output  24  BCD value per digit to the sevenSeg decoders, packed like DATE_A.
blank  output  6  per-digit blank, 1 = digit off; bit n maps to hexn.
mode  output  2  current FSM state: 0 = SHOW_A, 1 = SHOW_B, 2 = AUTO.

Behaviour:
- Reset values:
  - Sync flops and debounced levels = 1 (released).
  - Debounce and dwell counters = 0.
  - invert = 0, mode = SHOW_A, sel = A.
  - leds = 0.
  - digits = DATE_A.
  - blank = {SUPPRESS_LZ & (DATE_A[23:20]==0), 5'b0}.
- Input sync: each key bit passes through a 2-flop synchronizer.
- Debounce, per key:
  - Counter clears whenever the synced value equals the debounced level.
  - Otherwise it increments; on reaching DEBOUNCE_CYCLES-1 the debounced level takes the synced value and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never change the level.
- Press event: one-cycle pulse on a debounced 1->0 transition.
  - Release generates nothing.
  - A held key generates exactly one event.
  - Worst-case latency from raw edge to event = 2 + DEBOUNCE_CYCLES cycles.
- Invert: the key[0] event toggles invert.
  - leds[7:0] = switch ^ {8{invert}}, registered, one cycle after a switch change or the toggle.
- Mode FSM, advanced only by the key[1] event: SHOW_A -> SHOW_B -> AUTO -> SHOW_A. State 3 is illegal; it recovers to SHOW_A on the next clock.
  - SHOW_A: sel = A.
  - SHOW_B: sel = B.
  - AUTO:
    - On entry: sel = A, dwell counter = 0.
    - The counter increments each cycle. At DWELL_CYCLES-1 it wraps to 0 and sel toggles.
    - The first toggle occurs exactly DWELL_CYCLES cycles after entry.
  - The dwell counter is held at 0 outside AUTO.
- Outputs:
  - digits = sel ? DATE_B : DATE_A, registered, updating the cycle after sel changes.
  - blank[5] = SUPPRESS_LZ & (digits[23:20]==0), computed from the registered digit value.
  - blank[4:0] = 0.
  - mode and leds[9:8] reflect the registered state.
- Simultaneous events: key[0] and key[1] events in the same cycle are both applied (invert toggles and mode advances) independently.
- Key[1] event coinciding with the dwell wrap: the mode change wins (AUTO -> SHOW_A, sel = A, counter = 0).
- Reset mid-operation (mid-debounce or mid-dwell): all outputs go to reset values asynchronously. Release of reset is synchronous to clk; the first event needs a fresh full debounce.

Test Plan:
(Bench uses DEBOUNCE_CYCLES=4, DWELL_CYCLES=10.)
- Reset with switch=8'hA5 -> leds=0 during reset; leds=10'h0A5 one cycle after release; digits=24'h082301; blank=6'b100000; mode=0.
- key[0] low for 20 cycles then high -> exactly one event. leds[7:0]=8'h5A and leds[8]=1 no later than 2+4+1 cycles after the press. Release causes no change.
- key[0] low-pulse of 3 cycles, repeated 5 times with 3 high cycles between -> no event; leds stay 10'h0A5.
- Three clean key[1] presses:
  - After press 1: mode=1, digits=24'h082401.
  - After press 2: mode=2, leds[9]=1.
  - In AUTO: digits alternate A/B every 10 cycles, first switch to B exactly 10 cycles after entry.
  - After press 3: mode=0, digits=24'h082301.
- key[0] and key[1] pressed on the same cycle while in SHOW_A with invert=0 -> one cycle after the events, invert=1 and mode=1.
- In AUTO with dwell counter at 6, assert reset for 1 cycle -> mode=0, digits=DATE_A, leds=0 immediately. A key held low across reset release yields an event only after 2+4 cycles.
